// File: rtl/rv32i_pkg.sv
// Shared RV32I register-file constants and the debug dump FSM state encoding.
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } dump_state_e;

endpackage

// File: rtl/reg_dump_rv32i.sv
// Debug read-out engine: walks registers FIRST_REG..LAST_REG through an async
// read port and streams each (index, value) pair over a valid/ready interface.
module reg_dump_rv32i
    import rv32i_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dump_start,
    output logic                  dump_busy,
    output logic                  dump_done,
    output logic [REG_ADDR_W-1:0] rf_addr,
    input  logic [XLEN-1:0]       rf_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_addr,
    output logic [XLEN-1:0]       out_data,
    output logic                  out_last
);

    if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > NUM_REGS - 1) begin : g_bad_range
        $error("reg_dump_rv32i: invalid register range FIRST_REG=%0d LAST_REG=%0d",
               FIRST_REG, LAST_REG);
    end

    localparam logic [REG_ADDR_W-1:0] FIRST_IDX = FIRST_REG[REG_ADDR_W-1:0];
    localparam logic [REG_ADDR_W-1:0] LAST_IDX  = LAST_REG[REG_ADDR_W-1:0];

    dump_state_e           state_q, state_d;
    logic [REG_ADDR_W-1:0] idx_q, idx_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       data_q, data_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= FIRST_IDX;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        data_d    = data_q;
        out_valid = 1'b0;
        dump_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                idx_d = FIRST_IDX;
                if (dump_start) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Each register is sampled at its own FETCH edge; no snapshot.
                data_d  = rf_data;
                addr_d  = idx_q;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                dump_done = 1'b1;
                idx_d     = FIRST_IDX;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dump_busy = (state_q != ST_IDLE);
    assign rf_addr   = idx_q;
    assign out_addr  = addr_q;
    assign out_data  = data_q;
    assign out_last  = out_valid && (addr_q == LAST_IDX);

endmodule

// File: doc/reg_dump_rv32i.md
# reg_dump_rv32i

Debug read-out engine for the RV32I register file: on a start pulse it walks a parameterised range of register addresses through one asynchronous read port, captures each value, and streams it out as address/data words over a valid/ready interface. It sits beside the register file on the halt/debug path and feeds a debug serializer (UART/JTAG bridge). The top level muxes its `rf_addr` onto a read port only while `dump_busy` is high.

## Interface
Parameters:
- `FIRST_REG`, default 0: first register index dumped (0..31).
- `LAST_REG`, default 31: last register index dumped (FIRST_REG..31).

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `dump_start`  in  1  request to start a dump; sampled only in IDLE.
- `dump_busy`  out  1  high in every state except IDLE.
- `dump_done`  out  1  one-cycle pulse after the last word is accepted.
- `rf_addr`  out  5  read-port address driven to the register file.
- `rf_data`  in  32  asynchronous read data returned for `rf_addr`.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts the word when high with `out_valid`.
- `out_addr`  out  5  register index of the current word.
- `out_data`  out  32  captured register value.
- `out_last`  out  1  high with `out_valid` on the LAST_REG word.

## Operation
- States: IDLE, FETCH, SEND, DONE. Index register `idx` (5 bits).
- IDLE: `idx` = FIRST_REG. `dump_start` = 1 → FETCH.
- FETCH: `rf_addr` = `idx`; at the clock edge, capture `rf_data` into `out_data`, `idx` into `out_addr` → SEND.
- SEND: `out_valid` = 1; `out_data`/`out_addr`/`out_last` held stable until handshake (`out_valid & out_ready`). On handshake: if `idx` == LAST_REG → DONE, else `idx` + 1 → FETCH.
- DONE: `dump_done` = 1 for one cycle → IDLE. `dump_start` is ignored here.
- `dump_start` outside IDLE is ignored, with no queuing.
- `rf_addr` = `idx` in all states. Its value outside FETCH is don't-care to the register file, but it must be deterministic.
- No atomic snapshot: each value is taken at its own FETCH edge. A register-file write landing at or before that edge is visible; a later write is not.
- x0 is read through the port like any register. The register file returns 0 for it.
- `idx` never increments past LAST_REG, so no wrap-around occurs.
- Elaboration-time error if FIRST_REG > LAST_REG or LAST_REG > 31.

## Timing
- Reset values: `dump_busy`=0, `dump_done`=0, `out_valid`=0, `out_last`=0, `out_addr`=0, `out_data`=0, `rf_addr`=FIRST_REG. State = IDLE.
- Reset mid-operation: next cycle IDLE, `out_valid`=0, no `dump_done` pulse, any in-flight word is dropped.
- With `dump_start` seen at edge E0 and `out_ready` held high:
  - word k (k = 0 .. N−1, N = LAST_REG−FIRST_REG+1) is valid in cycle 2+2k;
  - `dump_done` is high in cycle 2N+1;
  - IDLE resumes in cycle 2N+2.
- Throughput is one word per 2 cycles minimum. Each stall cycle (`out_ready`=0) adds exactly one cycle.
- The read path is combinational `rf_addr` → `rf_data` → capture register, within one clock period.

## Structure
- Shared package/include `rv32i_pkg`: XLEN=32, REG_ADDR_W=5, NUM_REGS=32, and the dump state encoding (IDLE=0, FETCH=1, SEND=2, DONE=3).
- Single module, no sub-modules. The FSM, index counter and output capture register are all local.

## Test plan
- Full dump: preload xi = 32'h1000_0000+i (x0=0), `out_ready`=1, pulse `dump_start` → 32 words, addr 0..31, data 0 then 32'h1000_0001..32'h1000_001F, `out_last` only on addr 31, `dump_done` in cycle 65.
- Backpressure: drop `out_ready` for 5 cycles while word addr 3 is valid → addr/data stay 3/32'h1000_0003, no skip or duplicate, `dump_done` 5 cycles later than in the full dump.
- Ignored start: pulse `dump_start` in FETCH, SEND and DONE → exactly one dump of 32 words, a single `dump_done`, then IDLE.
- Reset mid-dump: assert `reset` while word addr 10 is valid → next cycle `out_valid`=0, `dump_busy`=0, no `dump_done`. A new start re-dumps from addr 0.
- Single register: FIRST_REG=LAST_REG=5 → one word, addr 5, `out_last`=1, `dump_done` in cycle 3.
- Write race: write x7=32'hDEAD_BEEF one edge before word 7's FETCH edge → DEAD_BEEF is emitted. Write it one edge after → 32'h1000_0007 is emitted.
